pulse_meter: RTL and testbench

- Downstream consumer of the pulse-generator stage.
- Takes an asynchronous pulse train `sig_in`, synchronizes it into the `clk` domain, detects rising edges and counts them over a programmable gate window of N `clk` cycles.
- Presents the result on a valid/ready handshake to the next stage; used as the measurement block in pulse/clock testbenches.

---
 rtl/pulse_meter.sv | 108 ++++++++++
 tb/tb_pulse_meter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// pulse_meter: synchronizes an asynchronous pulse train, detects rising edges
// and counts them over a programmable window, reporting on a valid/ready port.
`default_nettype none
`timescale 1ns/100ps

module pulse_meter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             sig_in,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             valid,
  input  logic             ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [WIN_W-1:0] TIMER_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               s1_q, s2_q, s3_q;
  logic               rise_w;

  // s1/s2 form the synchronizer; s3 only delays s2 for edge detection.
  assign rise_w = s2_q & ~s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = '0;
          ovf_d   = 1'b0;
          if (win_len != '0) begin
            timer_d = win_len;
            state_d = ST_COUNT;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_COUNT: begin
        if (rise_w) begin
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        timer_d = timer_q - 1'b1;
        if (timer_q == TIMER_ONE) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_COUNT);
  assign valid    = (state_q == ST_HOLD);
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: randomized self-checking bench for pulse_meter (8-bit and
// 4-bit count instances driven in parallel) against an edge-history model.
`default_nettype none
`timescale 1ns/100ps

module tb_pulse_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic        sig_in = 1'b0;
  logic        ready = 1'b0;
  logic        busy8, ovf8, valid8;
  logic [7:0]  count8;
  logic        busy4, ovf4, valid4;
  logic [3:0]  count4;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_meter #(.CNT_W(8), .WIN_W(16)) dut8 (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len), .sig_in(sig_in),
    .busy(busy8), .count(count8), .overflow(ovf8), .valid(valid8), .ready(ready)
  );

  pulse_meter #(.CNT_W(4), .WIN_W(16)) dut4 (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len), .sig_in(sig_in),
    .busy(busy4), .count(count4), .overflow(ovf4), .valid(valid4), .ready(ready)
  );

  always #1 clk = ~clk;

  // samp[n]: value the synchronizer captured at rising edge n (0 while in reset)
  int cyc = 0;
  bit samp [0:40000];
  always @(posedge clk) begin
    cyc = cyc + 1;
    samp[cyc] = reset ? 1'b0 : sig_in;
  end

  // background pulse generator, updated on falling edges
  bit gen_on = 0;
  bit gen_rand = 0;
  int gen_hi = 3, gen_lo = 9, gen_left = 1;
  always @(negedge clk) begin
    if (gen_on) begin
      if (gen_left <= 1) begin
        sig_in = ~sig_in;
        gen_left = sig_in ? gen_hi : gen_lo;
        if (gen_rand) gen_left = $urandom_range(2, 9);
      end else begin
        gen_left = gen_left - 1;
      end
    end
  end

  // Rising edges of the sampled input whose detection (two edges later) lands
  // on one of the window's counting edges t0+1 .. t0+W.
  function automatic int model_edges(input int t0, input int w);
    int n = 0;
    for (int m = t0 + 1; m <= t0 + w; m++)
      if (m >= 3 && samp[m-2] && !samp[m-3]) n++;
    return n;
  endfunction

  function automatic int sat(input int e, input int maxv);
    return (e > maxv) ? maxv : e;
  endfunction

  int t0, exp_e, busy8_n, busy4_n;

  // Opens one window; leaves the bench on the falling edge where valid should
  // first be high. rise_at raises sig_in on that busy-cycle index; poke pulses
  // start and holds ready during the window.
  task automatic run_window(input int w, input int rise_at, input bit poke);
    start = 1'b1;
    win_len = w[15:0];
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    busy8_n = 0;
    busy4_n = 0;
    for (int i = 0; i < w; i++) begin
      if (i == rise_at) sig_in = 1'b1;
      start = poke && (i == w / 2);
      ready = poke;
      busy8_n += int'(busy8);
      busy4_n += int'(busy4);
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b0;
    exp_e = model_edges(t0, w);
  endtask

  task automatic release_result();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy8, valid8, ovf8, count8, busy4, valid4, ovf4, count4} !== '0) begin
      n_bad++;
      $display("FAIL reset_in: got %h expected 0", {busy8, valid8, ovf8, count8, busy4, valid4, ovf4, count4});
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({busy8, valid8, ovf8, count8} !== '0) begin
      n_bad++;
      $display("FAIL reset_after: got %h expected 0", {busy8, valid8, ovf8, count8});
    end
  endtask

  task automatic test_basic();
    gen_on = 1; gen_rand = 0; gen_hi = 3; gen_lo = 9;
    repeat (20) @(negedge clk);
    run_window(120, -1, 0);
    n_cmp++;
    if (busy8_n !== 120) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d expected 120", busy8_n); end
    n_cmp++;
    if (valid8 !== 1'b1 || busy8 !== 1'b0) begin n_bad++; $display("FAIL basic_valid: got v=%b b=%b expected v=1 b=0", valid8, busy8); end
    n_cmp++;
    if (count8 !== 8'd10 || int'(count8) !== exp_e) begin n_bad++; $display("FAIL basic_count8: got %0d expected 10 (model %0d)", count8, exp_e); end
    n_cmp++;
    if (ovf8 !== 1'b0 || count4 !== 4'd10 || ovf4 !== 1'b0) begin n_bad++; $display("FAIL basic_dut4: got c=%0d o=%b/%b expected c=10 o=0", count4, ovf8, ovf4); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (valid8 !== 1'b1 || count8 !== 8'd10) begin n_bad++; $display("FAIL basic_hold%0d: got v=%b c=%0d expected v=1 c=10", k, valid8, count8); end
    end
    release_result();
    n_cmp++;
    if (valid8 !== 1'b0 || busy8 !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got v=%b b=%b expected 0 0", valid8, busy8); end
  endtask

  task automatic test_zero_window();
    run_window(0, -1, 0);
    n_cmp++;
    if (valid8 !== 1'b1 || busy8 !== 1'b0 || count8 !== 8'd0 || ovf8 !== 1'b0 || valid4 !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_win: got v=%b b=%b c=%0d o=%b expected v=1 b=0 c=0 o=0", valid8, busy8, count8, ovf8);
    end
    release_result();
  endtask

  task automatic test_saturate();
    gen_on = 1; gen_rand = 0; gen_hi = 2; gen_lo = 2;
    repeat (8) @(negedge clk);
    run_window(100, -1, 0);
    n_cmp++;
    if (count4 !== 4'd15 || ovf4 !== 1'b1) begin n_bad++; $display("FAIL sat4: got c=%0d o=%b expected c=15 o=1", count4, ovf4); end
    n_cmp++;
    if (int'(count8) !== exp_e || ovf8 !== 1'b0) begin n_bad++; $display("FAIL sat_c8: got c=%0d o=%b expected c=%0d o=0", count8, ovf8, exp_e); end
    release_result();
    run_window(1200, -1, 0);
    n_cmp++;
    if (int'(count8) !== sat(exp_e, 255) || ovf8 !== (exp_e > 255)) begin
      n_bad++;
      $display("FAIL sat8: got c=%0d o=%b expected c=%0d o=%b", count8, ovf8, sat(exp_e, 255), exp_e > 255);
    end
    release_result();
  endtask

  task automatic test_last_cycle_edge();
    gen_on = 0;
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
    run_window(5, 2, 0);
    n_cmp++;
    if (count8 !== 8'd1 || exp_e !== 1) begin n_bad++; $display("FAIL last_edge_in: got %0d expected 1", count8); end
    release_result();
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
    run_window(5, 3, 0);
    n_cmp++;
    if (count8 !== 8'd0 || exp_e !== 0) begin n_bad++; $display("FAIL last_edge_out: got %0d expected 0", count8); end
    release_result();
    sig_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    int vcount = 0;
    gen_on = 1; gen_rand = 1;
    repeat (5) @(negedge clk);
    start = 1'b1;
    win_len = 16'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #0.5 reset = 1'b1;
    #0.2;
    n_cmp++;
    if ({busy8, valid8, ovf8, count8, busy4, count4} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got b=%b v=%b o=%b c=%0d expected all 0", busy8, valid8, ovf8, count8);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      vcount += int'(valid8) + int'(busy8);
      @(negedge clk);
    end
    n_cmp++;
    if (vcount !== 0) begin n_bad++; $display("FAIL reset_no_valid: got %0d active cycles expected 0", vcount); end
    run_window(80, -1, 0);
    n_cmp++;
    if (int'(count8) !== exp_e || int'(count4) !== sat(exp_e, 15) || valid8 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_fresh: got c=%0d/%0d expected %0d/%0d", count8, count4, exp_e, sat(exp_e, 15));
    end
    release_result();
  endtask

  task automatic test_start_ignored();
    int act = 0;
    gen_on = 1; gen_rand = 1;
    run_window(40, -1, 1);
    n_cmp++;
    if (busy8_n !== 40 || valid8 !== 1'b1 || int'(count8) !== exp_e) begin
      n_bad++;
      $display("FAIL poke_count: got busy=%0d c=%0d expected busy=40 c=%0d", busy8_n, count8, exp_e);
    end
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      act += int'(valid8) + int'(busy8) + int'(valid4) + int'(busy4);
      @(negedge clk);
    end
    n_cmp++;
    if (act !== 0) begin n_bad++; $display("FAIL poke_idle: got %0d active cycles expected 0", act); end
  endtask

  task automatic test_random();
    int w;
    gen_on = 1; gen_rand = 1;
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(1, 7)) @(negedge clk);
      w = $urandom_range(1, 300);
      run_window(w, -1, 0);
      n_cmp++;
      if (busy8_n !== w || busy4_n !== w || valid8 !== 1'b1 ||
          int'(count8) !== sat(exp_e, 255) || ovf8 !== (exp_e > 255) ||
          int'(count4) !== sat(exp_e, 15) || ovf4 !== (exp_e > 15)) begin
        n_bad++;
        $display("FAIL rand%0d w=%0d: got busy=%0d c8=%0d c4=%0d o4=%b expected busy=%0d c8=%0d c4=%0d o4=%b",
                 n, w, busy8_n, count8, count4, ovf4, w, sat(exp_e, 255), sat(exp_e, 15), exp_e > 15);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_window();
    test_saturate();
    test_last_cycle_edge();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
